// File: rtl/ac_pkg.sv
// Shared types for the multi-byte add/sub/compare sequencer.
// Contents: operation encoding, sequencer state encoding, request-op decode helper.
// No ports; imported by ac_mp_sequencer.
package ac_pkg;

  // Operation encoding matches the raw req_op field; 2'b11 is folded onto CMP.
  typedef enum logic [1:0] {
    AC_OP_ADD = 2'b00,
    AC_OP_SUB = 2'b01,
    AC_OP_CMP = 2'b10
  } ac_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FLAG = 2'b10,
    DONE = 2'b11
  } ac_state_e;

  // The reserved encoding behaves as a compare: flags only, no result bytes.
  function automatic ac_op_e ac_decode_op(input logic [1:0] raw);
    ac_op_e op;
    case (raw)
      2'b00:   op = AC_OP_ADD;
      2'b01:   op = AC_OP_SUB;
      default: op = AC_OP_CMP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ac_mp_sequencer.sv
// Multi-byte ADD/SUB/CMP sequencer driving an 8-bit carry-chained add/sub datapath.
// Ports: request (req_*), LSB-first operand pair stream (opnd_*), LSB-first result
//        stream (res_*), completion pulse/flags (done, flag_*), datapath side (alu_*).
// One byte per cycle; operand intake stalls while an undrained result byte is held.
module ac_mp_sequencer
  import ac_pkg::*;
#(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  // request
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [LEN_W-1:0] req_len,
  // operand pairs
  input  logic             opnd_valid,
  output logic             opnd_ready,
  input  logic [7:0]       opnd_a,
  input  logic [7:0]       opnd_b,
  // result bytes
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_byte,
  output logic             res_last,
  // completion
  output logic             done,
  output logic             flag_sign,
  output logic             flag_z,
  // datapath
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic             alu_sub_sel,
  output logic             alu_csel,
  output logic             alu_cmp,
  output logic             alu_addsub,
  input  logic [7:0]       alu_sum,
  input  logic             alu_sign
);

  ac_state_e        state_q;
  ac_op_e           op_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic             zacc_q;
  logic             res_valid_q;
  logic [7:0]       res_byte_q;
  logic             res_last_q;
  logic             done_q;
  logic             flag_sign_q;
  logic             flag_z_q;

  logic             run;
  logic             is_cmp;
  logic             last_byte;
  logic             opnd_hs;
  logic             res_load;
  logic             res_valid_d;

  // Datapath-facing controls are gated by rst so a reset cycle never
  // disturbs the datapath carry/flag registers or accepts an operand.
  assign run       = (state_q == RUN) && !rst;
  assign is_cmp    = (op_q == AC_OP_CMP);
  assign last_byte = (cnt_q == (len_q - LEN_W'(1)));

  // CMP produces no result bytes, so it never waits on the result register.
  assign opnd_ready = run && (!res_valid_q || res_ready || is_cmp);
  assign opnd_hs    = opnd_valid && opnd_ready;
  assign res_load   = opnd_hs && !is_cmp;

  assign req_ready   = (state_q == IDLE) && !rst;
  assign alu_a       = run ? opnd_a : 8'h00;
  assign alu_b       = run ? opnd_b : 8'h00;
  assign alu_sub_sel = run && (op_q != AC_OP_ADD);
  // First byte takes its carry-in from sub_sel, so stale datapath carry is ignored.
  assign alu_csel    = !run || (cnt_q == '0);
  // Carry capture and flag update only on real handshakes; stalls leave both alone.
  assign alu_addsub  = opnd_hs;
  assign alu_cmp     = !(opnd_hs && last_byte);

  // A load wins over a simultaneous drain: the new byte replaces the old one.
  always_comb begin
    res_valid_d = res_valid_q;
    if (res_load) begin
      res_valid_d = 1'b1;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= AC_OP_ADD;
      len_q       <= '0;
      cnt_q       <= '0;
      zacc_q      <= 1'b1;
      res_valid_q <= 1'b0;
      res_byte_q  <= 8'h00;
      res_last_q  <= 1'b0;
      done_q      <= 1'b0;
      flag_sign_q <= 1'b0;
      flag_z_q    <= 1'b1;
    end else begin
      done_q      <= 1'b0;
      res_valid_q <= res_valid_d;
      if (res_load) begin
        res_byte_q <= alu_sum;
        res_last_q <= last_byte;
      end

      case (state_q)
        IDLE: begin
          if (req_valid) begin
            op_q   <= ac_decode_op(req_op);
            len_q  <= req_len;
            cnt_q  <= '0;
            zacc_q <= 1'b1;
            if (req_len == '0) begin
              // Empty operation: report zero immediately, touch nothing else.
              flag_z_q    <= 1'b1;
              flag_sign_q <= 1'b0;
              state_q     <= DONE;
            end else begin
              state_q <= RUN;
            end
          end
        end

        RUN: begin
          if (opnd_hs) begin
            zacc_q <= zacc_q && (alu_sum == 8'h00);
            cnt_q  <= cnt_q + LEN_W'(1);
            if (last_byte) begin
              state_q <= FLAG;
            end
          end
        end

        // The datapath sign register was written on the falling edge of the
        // last byte's cycle, so it is stable to sample here.
        FLAG: begin
          flag_sign_q <= alu_sign;
          flag_z_q    <= zacc_q;
          state_q     <= DONE;
        end

        DONE: begin
          if (!res_valid_q) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign res_valid = res_valid_q;
  assign res_byte  = res_byte_q;
  assign res_last  = res_last_q;
  assign done      = done_q;
  assign flag_sign = flag_sign_q;
  assign flag_z    = flag_z_q;

endmodule

// File: tb/tb_ac_mp_sequencer.sv
module tb_ac_mp_sequencer;

  localparam int LEN_W = 4;

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [LEN_W-1:0] req_len;
  logic             opnd_valid;
  logic             opnd_ready;
  logic [7:0]       opnd_a;
  logic [7:0]       opnd_b;
  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_byte;
  logic             res_last;
  logic             done;
  logic             flag_sign;
  logic             flag_z;
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic             alu_sub_sel;
  logic             alu_csel;
  logic             alu_cmp;
  logic             alu_addsub;
  logic [7:0]       alu_sum;
  logic             alu_sign;

  int checks = 0;
  int failures = 0;

  logic [7:0] ta [16];
  logic [7:0] tbv[16];
  logic [7:0] last_res_byte;

  ac_mp_sequencer #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_len(req_len),
    .opnd_valid(opnd_valid), .opnd_ready(opnd_ready), .opnd_a(opnd_a), .opnd_b(opnd_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_byte(res_byte), .res_last(res_last),
    .done(done), .flag_sign(flag_sign), .flag_z(flag_z),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sub_sel(alu_sub_sel), .alu_csel(alu_csel),
    .alu_cmp(alu_cmp), .alu_addsub(alu_addsub), .alu_sum(alu_sum), .alu_sign(alu_sign)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Byte-wide carry-chained add/sub datapath the sequencer drives.
  logic       dp_carry = 1'b0;
  logic       dp_sign = 1'b0;
  logic       dp_cin;
  logic [8:0] dp_full;
  always_comb begin
    dp_cin  = alu_csel ? alu_sub_sel : dp_carry;
    dp_full = {1'b0, alu_a} + {1'b0, (alu_sub_sel ? ~alu_b : alu_b)} + {8'h00, dp_cin};
  end
  assign alu_sum  = dp_full[7:0];
  assign alu_sign = dp_sign;
  always @(posedge clk) if (alu_addsub) dp_carry <= dp_full[8];
  always @(negedge clk) if (!alu_cmp) dp_sign <= dp_full[7];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Whole-word arithmetic on the operand arrays: ADD is A+B, everything else A-B.
  function automatic logic [127:0] ref_result(input int op, input int len);
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] r;
    logic [127:0] mask;
    a = '0;
    b = '0;
    for (int i = 0; i < len; i++) begin
      a[8*i +: 8] = ta[i];
      b[8*i +: 8] = tbv[i];
    end
    r = (op == 0) ? a + b : a - b;
    mask = (len == 0) ? '0 : ((128'd1 << (8*len)) - 128'd1);
    return r & mask;
  endfunction

  // rr_mode: 0 = res_ready always high, 1 = random ready/valid, 2 = 4-cycle stall after byte 0
  task automatic run_op(input int op, input int len, input int rr_mode);
    logic [127:0] exp_r;
    logic [7:0]   rbytes[$];
    logic         rlast[$];
    int idx, k, ndone, done_k, stall_left, stalls, nexp, nres_at_done;
    logic exp_sign, exp_z;
    exp_r = ref_result(op, len);
    nexp = (op >= 2) ? 0 : len;
    exp_sign = (len == 0) ? 1'b0 : exp_r[8*len-1];
    exp_z = (exp_r == '0);
    idx = 0; k = 0; ndone = 0; done_k = -1; stall_left = 4; stalls = 0; nres_at_done = -1;

    @(posedge clk); #1;
    req_op = op[1:0]; req_len = len[LEN_W-1:0]; req_valid = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;

    while (k < 200 && !(ndone > 0 && k >= done_k + 2)) begin
      k++;
      if (idx < len) begin
        opnd_valid = (rr_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        opnd_a = ta[idx];
        opnd_b = tbv[idx];
      end else begin
        opnd_valid = 1'b0;
      end
      if (rr_mode == 1) res_ready = ($urandom_range(0, 2) != 0);
      else if (rr_mode == 2 && idx >= 1 && stall_left > 0) begin
        res_ready = 1'b0;
        stall_left--;
      end else res_ready = 1'b1;

      @(negedge clk);
      if (opnd_valid && opnd_ready) begin
        chk("alu_addsub_hs", 32'(alu_addsub), 32'd1);
        chk("alu_csel", 32'(alu_csel), 32'(idx == 0));
        chk("alu_sub_sel", 32'(alu_sub_sel), 32'(op != 0));
        chk("alu_a", 32'(alu_a), 32'(ta[idx]));
        chk("alu_cmp_hs", 32'(alu_cmp), 32'(idx != len - 1));
        idx++;
      end else if (opnd_valid) begin
        stalls++;
        chk("alu_addsub_stall", 32'(alu_addsub), 32'd0);
        chk("alu_cmp_stall", 32'(alu_cmp), 32'd1);
      end
      if (res_valid && res_ready) begin
        rbytes.push_back(res_byte);
        rlast.push_back(res_last);
      end
      if (done) begin
        ndone++;
        if (done_k < 0) begin
          done_k = k;
          nres_at_done = rbytes.size();
        end
      end
      @(posedge clk); #1;
    end
    opnd_valid = 1'b0;
    res_ready = 1'b1;

    chk("done_seen_in_budget", 32'(done_k >= 0), 32'd1);
    chk("done_pulses", 32'(ndone), 32'd1);
    chk("res_count", 32'(rbytes.size()), 32'(nexp));
    chk("drained_before_done", 32'(nres_at_done), 32'(nexp));
    chk("opnd_consumed", 32'(idx), 32'(len));
    for (int i = 0; i < rbytes.size() && i < nexp; i++) begin
      chk("res_byte", 32'(rbytes[i]), 32'(exp_r[8*i +: 8]));
      chk("res_last", 32'(rlast[i]), 32'(i == nexp - 1));
    end
    if (rbytes.size() > 0) last_res_byte = rbytes[rbytes.size()-1];
    chk("flag_sign", 32'(flag_sign), 32'(exp_sign));
    chk("flag_z", 32'(flag_z), 32'(exp_z));
    if (len == 0) chk("len0_done_latency", 32'(done_k), 32'd2);
    if (rr_mode == 2) chk("stall_seen", 32'(stalls > 0), 32'd1);
  endtask

  initial begin
    int rop;
    int rlen;
    rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_len = '0;
    opnd_valid = 1'b0; opnd_a = 8'h00; opnd_b = 8'h00; res_ready = 1'b1;
    last_res_byte = 8'h00;

    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready_after", 32'(req_ready), 32'd1);
    chk("rst_opnd_ready", 32'(opnd_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_byte", 32'(res_byte), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_flag_z", 32'(flag_z), 32'd1);
    chk("rst_flag_sign", 32'(flag_sign), 32'd0);
    chk("rst_alu_csel", 32'(alu_csel), 32'd1);
    chk("rst_alu_cmp", 32'(alu_cmp), 32'd1);
    chk("rst_alu_addsub", 32'(alu_addsub), 32'd0);

    // ADD len=2: 0x01FF + 0x0001 = 0x0200
    ta[0] = 8'hFF; tbv[0] = 8'h01; ta[1] = 8'h01; tbv[1] = 8'h00;
    run_op(0, 2, 0);
    // SUB len=1: 05-05
    ta[0] = 8'h05; tbv[0] = 8'h05;
    run_op(1, 1, 0);
    // CMP len=2: 0x0100 vs 0x0200
    ta[0] = 8'h00; tbv[0] = 8'h00; ta[1] = 8'h01; tbv[1] = 8'h02;
    run_op(2, 2, 0);
    // ADD len=3 with downstream stall
    ta[0] = 8'h80; tbv[0] = 8'h90; ta[1] = 8'h7F; tbv[1] = 8'h00; ta[2] = 8'h12; tbv[2] = 8'h34;
    run_op(0, 3, 2);
    // empty operation
    run_op(0, 0, 0);

    // reset during the second byte of a len=4 SUB
    for (int i = 0; i < 4; i++) begin ta[i] = 8'(i + 1); tbv[i] = 8'(i + 9); end
    @(posedge clk); #1;
    req_op = 2'b01; req_len = 4'd4; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; opnd_valid = 1'b1; opnd_a = ta[0]; opnd_b = tbv[0];
    @(negedge clk);
    chk("midrst_first_hs", 32'(opnd_ready), 32'd1);
    @(posedge clk); #1;
    opnd_a = ta[1]; opnd_b = tbv[1]; rst = 1'b1;
    @(negedge clk);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_addsub", 32'(alu_addsub), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; opnd_valid = 1'b0;
    @(negedge clk);
    chk("midrst_req_ready_after", 32'(req_ready), 32'd1);
    chk("midrst_res_valid", 32'(res_valid), 32'd0);
    chk("midrst_res_byte", 32'(res_byte), 32'd0);
    chk("midrst_flag_z", 32'(flag_z), 32'd1);
    chk("midrst_alu_sub_sel", 32'(alu_sub_sel), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("midrst_no_done", 32'(done), 32'd0);
      @(negedge clk);
    end
    ta[0] = 8'h02; tbv[0] = 8'h03;
    run_op(0, 1, 0);
    chk("post_rst_add", 32'(last_res_byte), 32'h05);

    // randomized operations, including the reserved op code
    for (int n = 0; n < 24; n++) begin
      rop = $urandom_range(0, 3);
      rlen = $urandom_range(1, 15);
      for (int i = 0; i < 16; i++) begin
        ta[i] = 8'($urandom);
        tbv[i] = ($urandom_range(0, 3) == 0) ? ta[i] : 8'($urandom);
      end
      run_op(rop, rlen, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ac_mp_sequencer.md
Name: ac_mp_sequencer

Overview:
- Controller that drives the 8-bit carry-chained add/sub datapath (AC_AddSub) to perform multi-byte ADD, SUB and CMP operations.
- Accepts an operation request and a little-endian stream of operand byte pairs, then issues one byte per cycle to the datapath.
- Collects the datapath sum bytes into a result stream and reports final sign/zero flags.
- Sits between the register-file/bus side and the byte-wide ALU.

Parameters:
LEN_W, 4, width of req_len; operation length is 1..2**LEN_W-1 bytes.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_valid  in  1  operation request valid
req_ready  out  1  sequencer idle, request accepted when valid&ready
req_op  in  2  operation: 00=ADD, 01=SUB, 10=CMP, 11=reserved (treated as CMP)
req_len  in  LEN_W  number of bytes
opnd_valid  in  1  operand byte pair valid
opnd_ready  out  1  operand pair accepted when valid&ready
opnd_a  in  8  operand A byte, LSB first
opnd_b  in  8  operand B byte, LSB first
res_valid  out  1  result byte valid
res_ready  in  1  downstream accepts result byte
res_byte  out  8  result byte, LSB first
res_last  out  1  marks final result byte
done  out  1  one-cycle pulse, operation complete
flag_sign  out  1  sign from final byte, held until next done
flag_z  out  1  whole-word zero, held until next done
alu_a  out  8  to datapath a
alu_b  out  8  to datapath b
alu_sub_sel  out  1  to datapath sub_sel
alu_csel  out  1  to datapath csel: 1 = initial carry from sub_sel, 0 = chained cin
alu_cmp  out  1  to datapath cmp, active-low flag update
alu_addsub  out  1  to datapath addsub, 1 = capture carry-out
alu_sum  in  8  from datapath sum
alu_sign  in  1  from datapath sign

Behaviour:
- Clocking and reset: single clock, clk; reset is synchronous and active-high on rst.
- Reset values:
  - req_ready=0 during reset, 1 the cycle after.
  - opnd_ready=0, res_valid=0, res_last=0, res_byte=0, done=0.
  - flag_sign=0, flag_z=1.
  - alu_a=alu_b=0, alu_sub_sel=0, alu_csel=1, alu_cmp=1, alu_addsub=0.
- States: IDLE, RUN, FLAG, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid: latch op and len, set count=0, clear the z accumulator to 1, then go to RUN.
  - If len==0: go straight to DONE with flag_z=1 and flag_sign=0; no operand is consumed and no result is produced.
- RUN:
  - opnd_ready = !res_valid | res_ready | (op==CMP).
  - alu_a/alu_b are driven combinationally from opnd_a/opnd_b.
  - alu_sub_sel = (op!=ADD).
  - alu_csel = (count==0).
  - alu_addsub = opnd_valid & opnd_ready.
  - alu_cmp = !(handshake & count==len-1).
- On each operand handshake:
  - The same posedge captures alu_sum.
  - If op!=CMP, load alu_sum into the result register with res_valid=1 and res_last=(count==len-1).
  - zacc &= (alu_sum==0).
  - count increments.
  - After the last byte, go to FLAG.
- Stalls: a cycle without a handshake holds alu_addsub=0 and alu_cmp=1, so the datapath carry and flags are not disturbed.
- FLAG: one cycle. Sample alu_sign into flag_sign (the datapath flag register updates on the negative edge of the last byte's cycle). Load zacc into flag_z. Go to DONE.
- DONE:
  - done=1 for exactly one cycle; return to IDLE only after any pending result byte has drained (res_valid=0).
  - done remains 0 while waiting on the drain and pulses in the exit cycle.
- Result register:
  - Holds its value while res_valid & !res_ready.
  - Clears res_valid on res_ready when no new load occurs.
  - A simultaneous drain and load takes the new byte.
- Multi-byte carry comes only from the datapath carry register; the first byte always forces csel=1, so stale datapath carry has no effect.
- Reset mid-operation: abandon the operation, drop res_valid, emit no done, restore reset values next cycle.
- req_valid outside IDLE is ignored (req_ready=0).

Decomposition:
- Shared package ac_pkg:
  - op enum: AC_OP_ADD, AC_OP_SUB, AC_OP_CMP.
  - state enum: IDLE, RUN, FLAG, DONE.
- No sub-module is needed. The single result holding register stays inline.

Test Plan:
- ADD len=2, pairs (FF,01),(01,00), res_ready=1 -> res bytes 00 then 02 (last), flag_z=0, flag_sign=0, one done pulse.
- SUB len=1, (05,05) -> res 00 last, flag_z=1, alu_sub_sel=1, alu_csel=1 on that byte.
- CMP len=2, A=0x0100, B=0x0200 -> no res_valid ever, flag_sign=1, flag_z=0.
- ADD len=3 with res_ready low for 4 cycles after the first byte -> opnd_ready deasserts; alu_addsub stays 0 during the stall; final bytes are correct; done only after the last byte drains.
- req_len=0 -> done two cycles after acceptance, flag_z=1, no operand consumed.
- rst asserted during the second byte of a len=4 SUB -> next cycle: reset values, no done; a following ADD len=1 (02,03) gives 05.
